muldiv_unit: RTL and testbench

- Iterative multiply/divide engine with architectural HI/LO registers in the EX stage.
- Takes the same rs/rt operand pair that drives the ALU A/B inputs.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and exposes HI/LO to the EX result mux for MFHI/MFLO.
- Raises a stall while a multi-cycle operation is in flight so the pipeline holds.

---
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The master drives the operands and control; the slave returns HI/LO and the status flags.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b, flush,
        input  hi, lo, busy, stall, done, div_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output hi, lo, busy, stall, done, div_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine that owns the architectural HI/LO registers.
// It computes one bit per cycle on magnitudes and applies the sign fixups in the DONE cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst_n,
    muldiv_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;

    logic               op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [2*WIDTH-1:0] result;

    assign op_signed = ~bus.op[0];
    assign a_mag     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc holds {partial remainder, dividend/quotient}, shifted left each step.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ok};

    assign prod_fix = neg_quo_q ? -acc_q : acc_q;
    assign quo_fix  = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign result   = dz_q ? acc_q : (is_div_q ? {rem_fix, quo_fix} : prod_fix);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d  = bus.op[1];
                            cnt_d     = '0;
                            neg_quo_d = op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_rem_d = op_signed & bus.a[WIDTH-1];
                            dz_d      = 1'b0;
                            state_d   = S_CALC;
                            if (bus.op[1]) begin
                                acc_d = {{WIDTH{1'b0}}, a_mag};
                                opb_d = b_mag;
                                if (bus.b == '0) begin
                                    // Divide by zero: result is fixed, skip the iterations.
                                    acc_d     = {bus.a, {WIDTH{1'b1}}};
                                    neg_quo_d = 1'b0;
                                    neg_rem_d = 1'b0;
                                    dz_d      = 1'b1;
                                    state_d   = S_DONE;
                                end
                            end else begin
                                acc_d = {{WIDTH{1'b0}}, b_mag};
                                opb_d = a_mag;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    hi_d = result[2*WIDTH-1:WIDTH];
                    lo_d = result[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.stall    = bus.busy | (bus.start & ~bus.op[2] & (state_q == S_IDLE));
    assign bus.done     = (state_q == S_DONE) & ~bus.flush;
    assign bus.div_zero = bus.done & dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected HI/LO into a scoreboard,
// and a monitor pops and compares each time the unit signals done.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    bit           mon_pend = 1'b0;
    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] cur_hi = '0;
    logic [W-1:0] cur_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_pend) begin
                check("result_hi", 64'(bus.hi), 64'(mon_e.hi));
                check("result_lo", 64'(bus.lo), 64'(mon_e.lo));
                mon_pend = 1'b0;
            end
            if (bus.done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1, expected no pending op");
                end else begin
                    mon_e = sb_q.pop_front();
                    check("div_zero", 64'(bus.div_zero), 64'(mon_e.dz));
                    mon_pend = 1'b1;
                    $display("[TB] done: expect hi=0x%08h lo=0x%08h dz=%0d", mon_e.hi, mon_e.lo, mon_e.dz);
                end
            end
        end
    end

    // Issue one mul/div op from the cycle after a posedge; optionally inject an MTHI start at cycle intr.
    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] ai,
                          input logic [W-1:0] bi, input logic [W-1:0] hi_e, input logic [W-1:0] lo_e,
                          input logic dz_e, input int lat_e, input int intr);
        exp_t e;
        int   cnt;
        bit   seen, stall_ok, hold_ok;
        e.hi = hi_e; e.lo = lo_e; e.dz = dz_e;
        sb_q.push_back(e);
        bus.start = 1'b1; bus.op = o; bus.a = ai; bus.b = bi;
        @(negedge clk);
        check({name, "_stall_c0"}, 64'(bus.stall), 64'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 0; seen = 1'b0; stall_ok = 1'b1; hold_ok = 1'b1;
        while (!seen && cnt < 200) begin
            @(negedge clk);
            cnt++;
            stall_ok &= (bus.stall === 1'b1) && (bus.busy === 1'b1);
            hold_ok  &= (bus.hi === cur_hi) && (bus.lo === cur_lo);
            if (bus.done === 1'b1) seen = 1'b1;
            else if (cnt == intr) begin
                @(posedge clk); #1;
                bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hDEADBEEF;
            end else if (cnt == intr + 1) begin
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
        end
        check({name, "_latency"}, 64'(cnt), 64'(lat_e));
        check({name, "_stall_busy"}, 64'(stall_ok), 64'd1);
        check({name, "_hilo_hold"}, 64'(hold_ok), 64'd1);
        @(posedge clk); #1;
        cur_hi = hi_e;
        cur_lo = lo_e;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit done_seen;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dz", 64'(bus.div_zero), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, -1);
        run_op("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 10);
        run_op("mult_min", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, -1);
        run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, -1);
        run_op("divu", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, -1);
        run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, -1);
        run_op("divu_zero", 3'b011, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1, -1);
        run_op("multu_after_dz", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, -1);

        // MTHI then MTLO back to back
        bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hA5A5A5A5;
        @(negedge clk);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        check("mthi_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.op = 3'b101; bus.a = 32'h5A5A5A5A;
        @(negedge clk);
        check("mthi_hi", 64'(bus.hi), 64'hA5A5A5A5);
        check("mthi_lo_kept", 64'(bus.lo), 64'(cur_lo));
        check("mtlo_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("mtlo_lo", 64'(bus.lo), 64'h5A5A5A5A);
        check("mtlo_hi_kept", 64'(bus.hi), 64'hA5A5A5A5);
        $display("[TB] mthi/mtlo: hi=0x%08h lo=0x%08h", bus.hi, bus.lo);
        cur_hi = 32'hA5A5A5A5; cur_lo = 32'h5A5A5A5A;

        // flush with start in idle drops an MTHI; op 110 is a no-op
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h11111111; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.op = 3'b110; bus.a = 32'h22222222;
        @(negedge clk);
        check("flush_mthi_hi", 64'(bus.hi), 64'(cur_hi));
        check("nop_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("nop_hi", 64'(bus.hi), 64'(cur_hi));
        check("nop_lo", 64'(bus.lo), 64'(cur_lo));
        check("nop_busy", 64'(bus.busy), 64'd0);
        $display("[TB] flush-in-idle and nop: hi=0x%08h lo=0x%08h", bus.hi, bus.lo);

        // flush mid-CALC
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'b011; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        check("flush_busy_c15", 64'(bus.busy), 64'd1);
        check("flush_done_c15", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_idle", 64'(bus.busy), 64'd0);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            done_seen |= (bus.done === 1'b1);
        end
        check("flush_no_done", 64'(done_seen), 64'd0);
        check("flush_hi", 64'(bus.hi), 64'(cur_hi));
        check("flush_lo", 64'(bus.lo), 64'(cur_lo));
        $display("[TB] divu flushed at cycle 15: hi=0x%08h lo=0x%08h", bus.hi, bus.lo);

        // async reset mid-CALC
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_hi", 64'(bus.hi), 64'd0);
        check("arst_lo", 64'(bus.lo), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_stall", 64'(bus.stall), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            done_seen |= (bus.done === 1'b1);
        end
        check("arst_no_done", 64'(done_seen), 64'd0);
        $display("[TB] reset mid-calc: hi=0x%08h lo=0x%08h busy=%0d", bus.hi, bus.lo, bus.busy);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
